// File: rtl/cell_pkt_injector_if.sv
// AXI-Stream style link bundle (32-bit data, tlast) shared by the upstream and
// downstream sides of each Aurora TX link.
interface cell_pkt_injector_if;
  // A beat transfers on a cycle where tvalid and tready are both high. While
  // tvalid is high the master holds tdata/tlast stable until tready is seen.
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/cell_pkt_injector.sv
// CCW/CW link interposer: passes both links through and, on an FAstrobe rising
// edge, injects a burst of fake BPM packets on one link. Optional passthrough
// header cell-index increment: CELL_PKT_INJECTOR_AUTOINC_EN.
module cell_pkt_injector #(
  parameter int PKT_WORDS = 5,
  parameter int GAP       = 2,
  parameter int BW        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fa_strobe_i,
  input  logic                out_ccw_i,
  input  logic [4:0]          cell_index_i,
  input  logic [8:0]          fofb_index_i,
  input  logic [BW-1:0]       burst_len_i,
  cell_pkt_injector_if.slave  ccw_up,
  cell_pkt_injector_if.master ccw_dn,
  cell_pkt_injector_if.slave  cw_up,
  cell_pkt_injector_if.master cw_dn,
  output logic                busy_o,
  output logic [BW-1:0]       pkts_sent_o,
  output logic [1:0]          state_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_BEAT = 4'(PKT_WORDS - 1);

  state_e        state_q, state_d;
  logic          strobe_q;
  logic          sel_ccw_q, sel_ccw_d;
  logic [4:0]    cell_q, cell_d;
  logic [8:0]    fofb_q, fofb_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [BW-1:0] pkts_q, pkts_d;
  logic [3:0]    beat_q, beat_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   gap_q, gap_d;
  logic          in_pkt_ccw_q, in_pkt_ccw_d;
  logic          in_pkt_cw_q, in_pkt_cw_d;

  logic          trig, ovr, ovr_ccw, ovr_cw;
  logic          sel_in_pkt, sel_ready;
  logic          gen_valid, gen_last;
  logic [31:0]   gen_data;
  logic [31:0]   ccw_pt_data, cw_pt_data;

  assign trig       = fa_strobe_i & ~strobe_q;
  assign sel_in_pkt = sel_ccw_q ? in_pkt_ccw_q : in_pkt_cw_q;
  assign sel_ready  = sel_ccw_q ? ccw_dn.tready : cw_dn.tready;

  always_comb begin
    gen_data = 32'hADADFACE;
    gen_last = 1'b0;
    if (beat_q == 4'd0) gen_data = {16'hA5BE, 1'b1, cell_q, 1'b0, fofb_q};
    else if (beat_q == LAST_BEAT) gen_last = 1'b1;
    else gen_data = {seq_q, 12'd0, beat_q};
  end

  always_comb begin
    state_d   = state_q;
    sel_ccw_d = sel_ccw_q;
    cell_d    = cell_q;
    fofb_d    = fofb_q;
    burst_d   = burst_q;
    pkts_d    = pkts_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    gap_d     = gap_q;
    ovr       = 1'b0;
    gen_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          sel_ccw_d = out_ccw_i;
          cell_d    = cell_index_i;
          fofb_d    = fofb_index_i;
          burst_d   = (burst_len_i == '0) ? BW'(1) : burst_len_i;
          pkts_d    = '0;
          seq_d     = '0;
          beat_d    = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Grab the link the same cycle it is seen idle so no upstream header slips in.
        if (!sel_in_pkt) begin
          ovr     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        ovr       = 1'b1;
        gen_valid = 1'b1;
        if (sel_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            pkts_d = pkts_q + 1'b1;
            seq_d  = seq_q + 16'd1;
            gap_d  = '0;
            // Override is held across a zero gap, so the link is known idle.
            if (pkts_d == burst_q) state_d = S_IDLE;
            else if (GAP == 0)     state_d = S_SEND;
            else                   state_d = S_GAP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        // The final gap cycle doubles as the idle check, keeping the gap exact.
        if (int'(gap_q) >= GAP - 1) begin
          if (!sel_in_pkt) begin
            ovr     = 1'b1;
            state_d = S_SEND;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ovr_ccw = ovr & sel_ccw_q;
  assign ovr_cw  = ovr & ~sel_ccw_q;

  always_comb begin
    in_pkt_ccw_d = in_pkt_ccw_q;
    in_pkt_cw_d  = in_pkt_cw_q;
    if (ccw_up.tvalid & ccw_dn.tready & ~ovr_ccw) in_pkt_ccw_d = ~ccw_up.tlast;
    if (cw_up.tvalid & cw_dn.tready & ~ovr_cw)    in_pkt_cw_d  = ~cw_up.tlast;
  end

  always_comb begin
    ccw_pt_data = ccw_up.tdata;
    cw_pt_data  = cw_up.tdata;
`ifdef CELL_PKT_INJECTOR_AUTOINC_EN
    if (!in_pkt_ccw_q) ccw_pt_data[14:10] = ccw_up.tdata[14:10] + 5'd1;
    if (!in_pkt_cw_q)  cw_pt_data[14:10]  = cw_up.tdata[14:10] + 5'd1;
`else
`endif
  end

  assign ccw_dn.tdata  = ovr_ccw ? gen_data  : ccw_pt_data;
  assign ccw_dn.tlast  = ovr_ccw ? gen_last  : ccw_up.tlast;
  assign ccw_dn.tvalid = ovr_ccw ? gen_valid : ccw_up.tvalid;
  assign ccw_up.tready = ~ovr_ccw & ccw_dn.tready;
  assign cw_dn.tdata   = ovr_cw  ? gen_data  : cw_pt_data;
  assign cw_dn.tlast   = ovr_cw  ? gen_last  : cw_up.tlast;
  assign cw_dn.tvalid  = ovr_cw  ? gen_valid : cw_up.tvalid;
  assign cw_up.tready  = ~ovr_cw & cw_dn.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      strobe_q     <= 1'b0;
      sel_ccw_q    <= 1'b0;
      cell_q       <= '0;
      fofb_q       <= '0;
      burst_q      <= '0;
      pkts_q       <= '0;
      beat_q       <= '0;
      seq_q        <= '0;
      gap_q        <= '0;
      in_pkt_ccw_q <= 1'b0;
      in_pkt_cw_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      strobe_q     <= fa_strobe_i;
      sel_ccw_q    <= sel_ccw_d;
      cell_q       <= cell_d;
      fofb_q       <= fofb_d;
      burst_q      <= burst_d;
      pkts_q       <= pkts_d;
      beat_q       <= beat_d;
      seq_q        <= seq_d;
      gap_q        <= gap_d;
      in_pkt_ccw_q <= in_pkt_ccw_d;
      in_pkt_cw_q  <= in_pkt_cw_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign pkts_sent_o = pkts_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_cell_pkt_injector.sv
// Directed bench for cell_pkt_injector: injection, bursts with gaps, waiting for
// a passthrough packet, downstream stalls, autoinc headers and mid-burst reset.
module tb_cell_pkt_injector;
  localparam int PKT_WORDS = 5;
  localparam int GAP       = 2;
  localparam int BW        = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fa_strobe;
  logic          out_ccw;
  logic [4:0]    cell_index;
  logic [8:0]    fofb_index;
  logic [BW-1:0] burst_len;
  logic          busy;
  logic [BW-1:0] pkts_sent;
  logic [1:0]    state;

  cell_pkt_injector_if ccw_up_if ();
  cell_pkt_injector_if ccw_dn_if ();
  cell_pkt_injector_if cw_up_if ();
  cell_pkt_injector_if cw_dn_if ();

  int errors = 0;
  int checks = 0;

  cell_pkt_injector #(.PKT_WORDS(PKT_WORDS), .GAP(GAP), .BW(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fa_strobe_i  (fa_strobe),
    .out_ccw_i    (out_ccw),
    .cell_index_i (cell_index),
    .fofb_index_i (fofb_index),
    .burst_len_i  (burst_len),
    .ccw_up       (ccw_up_if),
    .ccw_dn       (ccw_dn_if),
    .cw_up        (cw_up_if),
    .cw_dn        (cw_dn_if),
    .busy_o       (busy),
    .pkts_sent_o  (pkts_sent),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nx();
    @(posedge clk);
    #2;
  endtask

  task automatic sm();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int p, input int k, input logic [4:0] c,
                                       input logic [8:0] f);
    if (k == 0) return {16'hA5BE, 1'b1, c, 1'b0, f};
    else if (k == PKT_WORDS - 1) return 32'hADADFACE;
    else return {16'(p), 16'(k)};
  endfunction

  function automatic logic [31:0] pt_hdr(input logic [31:0] x);
    logic [31:0] y;
    y = x;
`ifdef CELL_PKT_INJECTOR_AUTOINC_EN
    y[14:10] = x[14:10] + 5'd1;
`endif
    return y;
  endfunction

  bit pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    int idx;
    rst = 1'b1;
    fa_strobe = 1'b0; out_ccw = 1'b0; cell_index = '0; fofb_index = '0; burst_len = '0;
    ccw_up_if.tdata = '0; ccw_up_if.tlast = 1'b0; ccw_up_if.tvalid = 1'b0;
    cw_up_if.tdata  = '0; cw_up_if.tlast  = 1'b0; cw_up_if.tvalid  = 1'b0;
    ccw_dn_if.tready = 1'b1; cw_dn_if.tready = 1'b1;
    nx(); nx();
    sm();
    chk("rst_busy", busy, 0);
    chk("rst_pkts", pkts_sent, 0);
    chk("rst_state", state, 0);
    chk("rst_ccw_valid", ccw_dn_if.tvalid, 0);
    nx();
    rst = 1'b0;

    // Single packet on CCW
    nx();
    burst_len = 8'd1; out_ccw = 1'b1; cell_index = 5'd3; fofb_index = 9'd9; fa_strobe = 1'b1;
    sm();
    chk("t1_idle_busy", busy, 0);
    nx();
    fa_strobe = 1'b0;
    sm();
    chk("t1_wait_state", state, 1);
    chk("t1_wait_busy", busy, 1);
    chk("t1_wait_valid", ccw_dn_if.tvalid, 0);
    for (int k = 0; k < PKT_WORDS; k++) begin
      nx();
      sm();
      chk($sformatf("t1_valid%0d", k), ccw_dn_if.tvalid, 1);
      chk($sformatf("t1_data%0d", k), ccw_dn_if.tdata, beat(0, k, 5'd3, 9'd9));
      chk($sformatf("t1_last%0d", k), ccw_dn_if.tlast, (k == PKT_WORDS - 1) ? 1 : 0);
      chk($sformatf("t1_cw_valid%0d", k), cw_dn_if.tvalid, 0);
      chk($sformatf("t1_cw_ready%0d", k), cw_up_if.tready, 1);
    end
    chk("t1_hdr_const", ccw_dn_if.tdata, 32'hADADFACE);
    nx();
    sm();
    chk("t1_done_busy", busy, 0);
    chk("t1_done_pkts", pkts_sent, 1);
    chk("t1_done_valid", ccw_dn_if.tvalid, 0);

    // Burst of three on CW with a two-cycle gap
    nx();
    burst_len = 8'd3; out_ccw = 1'b0; cell_index = 5'd1; fofb_index = 9'd2; fa_strobe = 1'b1;
    nx();
    fa_strobe = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < PKT_WORDS; k++) begin
        nx();
        sm();
        chk($sformatf("t2_valid_p%0d_k%0d", p, k), cw_dn_if.tvalid, 1);
        chk($sformatf("t2_data_p%0d_k%0d", p, k), cw_dn_if.tdata, beat(p, k, 5'd1, 9'd2));
      end
      if (p < 2) begin
        for (int g = 0; g < GAP; g++) begin
          nx();
          sm();
          chk($sformatf("t2_gap_p%0d_g%0d", p, g), cw_dn_if.tvalid, 0);
        end
      end
    end
    nx();
    sm();
    chk("t2_done_busy", busy, 0);
    chk("t2_done_pkts", pkts_sent, 3);

    // Strobe while a passthrough packet is in flight on CCW
    nx();
    burst_len = 8'd1; out_ccw = 1'b1; cell_index = 5'd3; fofb_index = 9'd9;
    ccw_up_if.tvalid = 1'b1; ccw_up_if.tdata = 32'h11110000; ccw_up_if.tlast = 1'b0;
    sm();
    chk("t3_pt_hdr", ccw_dn_if.tdata, pt_hdr(32'h11110000));
    chk("t3_pt_ready0", ccw_up_if.tready, 1);
    nx();
    ccw_up_if.tdata = 32'h22220001; fa_strobe = 1'b1;
    sm();
    chk("t3_pt_d1", ccw_dn_if.tdata, 32'h22220001);
    nx();
    fa_strobe = 1'b0; ccw_up_if.tdata = 32'h33330002; ccw_up_if.tlast = 1'b1;
    sm();
    chk("t3_wait_state", state, 1);
    chk("t3_pt_d2", ccw_dn_if.tdata, 32'h33330002);
    chk("t3_pt_ready2", ccw_up_if.tready, 1);
    nx();
    ccw_up_if.tdata = 32'h44440000; ccw_up_if.tlast = 1'b0;
    sm();
    chk("t3_take_ready", ccw_up_if.tready, 0);
    chk("t3_take_valid", ccw_dn_if.tvalid, 0);
    for (int k = 0; k < PKT_WORDS; k++) begin
      nx();
      sm();
      chk($sformatf("t3_inj%0d", k), ccw_dn_if.tdata, beat(0, k, 5'd3, 9'd9));
      chk($sformatf("t3_hold%0d", k), ccw_up_if.tready, 0);
    end
    nx();
    sm();
    chk("t3_resume_hdr", ccw_dn_if.tdata, pt_hdr(32'h44440000));
    chk("t3_resume_ready", ccw_up_if.tready, 1);
    chk("t3_resume_valid", ccw_dn_if.tvalid, 1);
    nx();
    ccw_up_if.tdata = 32'h55550001; ccw_up_if.tlast = 1'b1;
    sm();
    chk("t3_resume_d1", ccw_dn_if.tdata, 32'h55550001);
    chk("t3_resume_last", ccw_dn_if.tlast, 1);
    nx();
    ccw_up_if.tvalid = 1'b0; ccw_up_if.tlast = 1'b0;

    // Downstream stalls during injection, second strobe while busy
    nx();
    fa_strobe = 1'b1;
    nx();
    fa_strobe = 1'b0;
    idx = 0;
    for (int n = 0; n < 12 && idx < PKT_WORDS; n++) begin
      nx();
      ccw_dn_if.tready = pat[n];
      if (n == 2) fa_strobe = 1'b1;
      sm();
      chk($sformatf("t4_valid_n%0d", n), ccw_dn_if.tvalid, 1);
      chk($sformatf("t4_data_n%0d", n), ccw_dn_if.tdata, beat(0, idx, 5'd3, 9'd9));
      if (pat[n]) idx++;
    end
    chk("t4_all_beats", idx, PKT_WORDS);
    nx();
    ccw_dn_if.tready = 1'b1;
    sm();
    chk("t4_done_busy", busy, 0);
    chk("t4_done_pkts", pkts_sent, 1);
    for (int n = 0; n < 3; n++) begin
      nx();
      sm();
      chk($sformatf("t4_no_extra_state%0d", n), state, 0);
      chk($sformatf("t4_no_extra_valid%0d", n), ccw_dn_if.tvalid, 0);
    end
    fa_strobe = 1'b0;

    // Passthrough header cell index handling
    nx();
    ccw_up_if.tvalid = 1'b1; ccw_up_if.tdata = 32'hA5BEFC09; ccw_up_if.tlast = 1'b0;
    sm();
`ifdef CELL_PKT_INJECTOR_AUTOINC_EN
    chk("t5_hdr31", ccw_dn_if.tdata, 32'hA5BE8009);
`else
    chk("t5_hdr31", ccw_dn_if.tdata, 32'hA5BEFC09);
`endif
    nx();
    ccw_up_if.tdata = 32'hDEAD7C00; ccw_up_if.tlast = 1'b1;
    sm();
    chk("t5_data", ccw_dn_if.tdata, 32'hDEAD7C00);
    nx();
    ccw_up_if.tdata = 32'hA5BE9009;
    sm();
`ifdef CELL_PKT_INJECTOR_AUTOINC_EN
    chk("t5_hdr4", ccw_dn_if.tdata, 32'hA5BE9409);
`else
    chk("t5_hdr4", ccw_dn_if.tdata, 32'hA5BE9009);
`endif
    nx();
    ccw_up_if.tvalid = 1'b0; ccw_up_if.tlast = 1'b0;

    // Reset in the middle of a burst
    nx();
    burst_len = 8'd3; out_ccw = 1'b0; fa_strobe = 1'b1;
    nx();
    fa_strobe = 1'b0;
    for (int k = 0; k < PKT_WORDS + GAP + 1; k++) nx();
    sm();
    chk("t6_pre_pkts", pkts_sent, 1);
    chk("t6_pre_hdr", cw_dn_if.tdata, beat(1, 0, 5'd3, 9'd9));
    cw_up_if.tvalid = 1'b1; cw_up_if.tdata = 32'h0BAD0000; cw_up_if.tlast = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_data", cw_dn_if.tdata, pt_hdr(32'h0BAD0000));
    chk("t6_rst_valid", cw_dn_if.tvalid, 1);
    chk("t6_rst_ready", cw_up_if.tready, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pkts", pkts_sent, 0);
    cw_up_if.tvalid = 1'b0;
    nx();
    rst = 1'b0;
    nx();
    burst_len = 8'd0; fa_strobe = 1'b1;
    nx();
    fa_strobe = 1'b0;
    for (int k = 0; k < PKT_WORDS; k++) begin
      nx();
      sm();
      chk($sformatf("t6_new%0d", k), cw_dn_if.tdata, beat(0, k, 5'd3, 9'd9));
    end
    nx();
    sm();
    chk("t6_new_busy", busy, 0);
    chk("t6_new_pkts", pkts_sent, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
